smc_ahb_lite_if_mcs: RTL and testbench

//  AHB-lite slave front end for the Static Memory Controller, supporting NUM_CS external banks.

---
 rtl/smc_lite_pkg.sv | 33 +++
 rtl/smc_cs_decode.sv | 53 +++++
 rtl/smc_ahb_lite_if_mcs.sv | 167 ++++++++++++++++
 tb/tb_smc_ahb_lite_if_mcs.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/smc_lite_pkg.sv
// Shared constants and FSM encoding for the SMC AHB-lite front end.
package smc_lite_pkg;

    // AHB transfer types
    localparam logic [1:0] TRN_IDLE   = 2'b00;
    localparam logic [1:0] TRN_BUSY   = 2'b01;
    localparam logic [1:0] TRN_NONSEQ = 2'b10;
    localparam logic [1:0] TRN_SEQ    = 2'b11;

    // AHB transfer sizes
    localparam logic [2:0] SZ_BYTE  = 3'd0;
    localparam logic [2:0] SZ_HALF  = 3'd1;
    localparam logic [2:0] SZ_WORD  = 3'd2;
    localparam logic [2:0] SZ_DWORD = 3'd3;

    // AHB responses
    localparam logic [1:0] RSP_OKAY  = 2'b00;
    localparam logic [1:0] RSP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PEND = 3'd1,
        ST_BUSY = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } smc_state_e;

    // Largest legal hsize for a given data bus width (log2 of the byte lanes).
    function automatic logic [2:0] max_size(input int dw);
        return (dw == 64) ? SZ_DWORD : SZ_WORD;
    endfunction

endpackage

// File: rtl/smc_cs_decode.sv
// Combinational address-phase decode: one-hot bank select plus the three
// transfer error conditions (misaligned, oversize, unmapped bank).
module smc_cs_decode
    import smc_lite_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int NUM_CS    = 4,
    parameter int BANK_LSB  = 24,
    parameter int ERR_UNMAP = 1
) (
    input  logic [AW-1:0]     haddr,
    input  logic [2:0]        hsize,
    input  logic [1:0]        htrans,
    input  logic              hsel,
    output logic [NUM_CS-1:0] cs,
    output logic              mis_err,
    output logic              size_err,
    output logic              unmap_err
);

    localparam logic [2:0] MAX_SZ = max_size(DW);

    logic        xfer;
    logic [31:0] bank_idx;
    logic [31:0] bank_sel;
    logic [6:0]  low_bits;
    logic        unused_bits;

    // Middle address bits and htrans[0] play no part in the decode.
    assign unused_bits = ^{haddr, htrans[0]};

    // Bank index, wrap or flag out-of-range banks, and check size/alignment.
    always_comb begin
        xfer      = hsel & htrans[1];
        bank_idx  = 32'(haddr[AW-1:BANK_LSB]);
        bank_sel  = (ERR_UNMAP != 0) ? bank_idx : (bank_idx % 32'(NUM_CS));
        low_bits  = haddr[6:0];
        size_err  = xfer & (hsize > MAX_SZ);
        unmap_err = xfer && (ERR_UNMAP != 0) && (bank_idx >= 32'(NUM_CS));
        mis_err   = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if ((3'(i) < hsize) && low_bits[i]) begin
                mis_err = xfer;
            end
        end
        cs = '0;
        for (int i = 0; i < NUM_CS; i++) begin
            cs[i] = (bank_sel == 32'(i));
        end
    end

endmodule

// File: rtl/smc_ahb_lite_if_mcs.sv
// AHB-lite slave front end for the multi-bank Static Memory Controller.
// Registers the address phase, launches the core, stretches HREADY until the
// core finishes and produces the two-cycle ERROR response.
module smc_ahb_lite_if_mcs
    import smc_lite_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int NUM_CS    = 4,
    parameter int BANK_LSB  = 24,
    parameter int ERR_UNMAP = 1
) (
    input  logic              hclk,
    input  logic              n_sys_reset,
    input  logic              hsel,
    input  logic [AW-1:0]     haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [DW-1:0]     hwdata,
    input  logic              hready,
    input  logic              smc_idle,
    input  logic              smc_done,
    input  logic              mac_done,
    input  logic [DW-1:0]     read_data,
    output logic [DW-1:0]     smc_hrdata,
    output logic              smc_hready,
    output logic [1:0]        smc_hresp,
    output logic              smc_valid,
    output logic              new_access,
    output logic [AW-1:0]     addr,
    output logic [NUM_CS-1:0] cs,
    output logic [1:0]        xfer_size,
    output logic              n_read,
    output logic [DW-1:0]     write_data
);

    smc_state_e        state_q, state_d;
    logic [NUM_CS-1:0] dec_cs;
    logic              mis_err, size_err, unmap_err;
    logic              sample, acc_err, accept, latch_en;

    logic [AW-1:0]     addr_q;
    logic [NUM_CS-1:0] cs_q;
    logic [1:0]        size_q;
    logic              nread_q;
    logic              wcap_q;
    logic [DW-1:0]     wdata_q;

    smc_cs_decode #(
        .AW       (AW),
        .DW       (DW),
        .NUM_CS   (NUM_CS),
        .BANK_LSB (BANK_LSB),
        .ERR_UNMAP(ERR_UNMAP)
    ) u_decode (
        .haddr    (haddr),
        .hsize    (hsize),
        .htrans   (htrans),
        .hsel     (hsel),
        .cs       (dec_cs),
        .mis_err  (mis_err),
        .size_err (size_err),
        .unmap_err(unmap_err)
    );

    assign sample     = hsel & hready & htrans[1];
    assign acc_err    = mis_err | size_err | unmap_err;
    assign smc_valid  = sample & ~acc_err;
    assign smc_hrdata = read_data;
    assign addr       = addr_q;
    assign cs         = cs_q;
    assign xfer_size  = size_q;
    assign n_read     = nread_q;
    assign write_data = wdata_q;

    // Next state and bus response. States that can take a new address phase
    // set accept; the sample is then routed identically from each of them,
    // which gives back-to-back transfers with no bubble.
    always_comb begin
        state_d    = state_q;
        smc_hready = 1'b1;
        smc_hresp  = RSP_OKAY;
        new_access = 1'b0;
        latch_en   = 1'b0;
        accept     = 1'b0;
        case (state_q)
            ST_IDLE: accept = 1'b1;
            ST_PEND: begin
                smc_hready = 1'b0;
                if (smc_idle) begin
                    new_access = 1'b1;
                    state_d    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                smc_hready = smc_done & mac_done;
                if (smc_done & mac_done) begin
                    state_d = ST_IDLE;
                    accept  = 1'b1;
                end
            end
            ST_ERR1: begin
                smc_hready = 1'b0;
                smc_hresp  = RSP_ERROR;
                state_d    = ST_ERR2;
            end
            ST_ERR2: begin
                smc_hresp = RSP_ERROR;
                state_d   = ST_IDLE;
                accept    = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        if (accept && sample) begin
            if (acc_err) begin
                state_d = ST_ERR1;
            end else begin
                latch_en = 1'b1;
                if (smc_idle) begin
                    new_access = 1'b1;
                    state_d    = ST_BUSY;
                end else begin
                    state_d = ST_PEND;
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge hclk or negedge n_sys_reset) begin
        if (!n_sys_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Address-phase latches, held stable until the next accepted transfer.
    always_ff @(posedge hclk or negedge n_sys_reset) begin
        if (!n_sys_reset) begin
            addr_q  <= '0;
            cs_q    <= '0;
            size_q  <= '0;
            nread_q <= 1'b0;
        end else if (latch_en) begin
            addr_q  <= haddr;
            cs_q    <= dec_cs;
            size_q  <= hsize[1:0];
            nread_q <= hwrite;
        end
    end

    // Write data arrives one cycle after its address; grab it on that cycle.
    always_ff @(posedge hclk or negedge n_sys_reset) begin
        if (!n_sys_reset) begin
            wcap_q  <= 1'b0;
            wdata_q <= '0;
        end else begin
            wcap_q <= latch_en & hwrite;
            if (wcap_q) begin
                wdata_q <= hwdata;
            end
        end
    end

endmodule

// File: tb/tb_smc_ahb_lite_if_mcs.sv
// Testbench for smc_ahb_lite_if_mcs: decode table, directed corner sequences
// and randomized traffic against a transaction-level reference model.
module tb_smc_ahb_lite_if_mcs;
    import smc_lite_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NUM_CS = 4;

    logic hclk = 1'b0;
    always #5 hclk = ~hclk;

    logic              n_sys_reset, hsel, hwrite, hready, smc_idle, smc_done, mac_done;
    logic [AW-1:0]     haddr;
    logic [1:0]        htrans;
    logic [2:0]        hsize;
    logic [DW-1:0]     hwdata, read_data;

    logic [DW-1:0]     smc_hrdata, write_data;
    logic              smc_hready, smc_valid, new_access, n_read;
    logic [1:0]        smc_hresp, xfer_size;
    logic [AW-1:0]     addr;
    logic [NUM_CS-1:0] cs;

    logic [DW-1:0]     w_hrdata, w_write_data;
    logic              w_hready, w_valid, w_new_access, w_n_read;
    logic [1:0]        w_hresp, w_xfer_size;
    logic [AW-1:0]     w_addr;
    logic [NUM_CS-1:0] w_cs;

    // Single slave on the bus: the muxed ready is this slave's own ready.
    assign hready = smc_hready;

    smc_ahb_lite_if_mcs #(.AW(AW), .DW(DW), .NUM_CS(NUM_CS), .BANK_LSB(24), .ERR_UNMAP(1)) u_dut (
        .hclk(hclk), .n_sys_reset(n_sys_reset), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready), .smc_idle(smc_idle),
        .smc_done(smc_done), .mac_done(mac_done), .read_data(read_data), .smc_hrdata(smc_hrdata),
        .smc_hready(smc_hready), .smc_hresp(smc_hresp), .smc_valid(smc_valid),
        .new_access(new_access), .addr(addr), .cs(cs), .xfer_size(xfer_size), .n_read(n_read),
        .write_data(write_data)
    );

    smc_ahb_lite_if_mcs #(.AW(AW), .DW(DW), .NUM_CS(NUM_CS), .BANK_LSB(24), .ERR_UNMAP(0)) u_wrap (
        .hclk(hclk), .n_sys_reset(n_sys_reset), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready), .smc_idle(smc_idle),
        .smc_done(smc_done), .mac_done(mac_done), .read_data(read_data), .smc_hrdata(w_hrdata),
        .smc_hready(w_hready), .smc_hresp(w_hresp), .smc_valid(w_valid),
        .new_access(w_new_access), .addr(w_addr), .cs(w_cs), .xfer_size(w_xfer_size),
        .n_read(w_n_read), .write_data(w_write_data)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge hclk);
        #1;
    endtask

    task automatic bus_idle();
        hsel = 1'b0; htrans = TRN_IDLE; haddr = '0; hsize = SZ_BYTE; hwrite = 1'b0;
    endtask

    task automatic aphase(input logic [1:0] tr, input logic [31:0] a, input logic [2:0] sz, input logic wr);
        hsel = 1'b1; htrans = tr; haddr = a; hsize = sz; hwrite = wr;
    endtask

    typedef struct packed {
        logic        sel;
        logic [1:0]  trn;
        logic [31:0] a;
        logic [2:0]  sz;
        logic        wr;
        logic        ev;    // expected smc_valid, ERR_UNMAP=1
        logic        ee;    // expected ERROR response, ERR_UNMAP=1
        logic [3:0]  ec;    // expected latched cs, ERR_UNMAP=1
        logic        evw;   // expected smc_valid, ERR_UNMAP=0
        logic [3:0]  ecw;   // expected latched cs, ERR_UNMAP=0
    } vec_t;

    function automatic vec_t mk(input logic s, input logic [1:0] t, input logic [31:0] a,
                                input logic [2:0] z, input logic w, input logic ev, input logic ee,
                                input logic [3:0] ec, input logic evw, input logic [3:0] ecw);
        vec_t v;
        v.sel = s; v.trn = t; v.a = a; v.sz = z; v.wr = w;
        v.ev = ev; v.ee = ee; v.ec = ec; v.evw = evw; v.ecw = ecw;
        return v;
    endfunction

    vec_t vecs[13];
    vec_t v;

    // Reference model state: outstanding work described as flags/counters.
    logic        m_pend, m_inflt, m_cap;
    int          m_err;
    logic [31:0] m_addr, m_wd;
    logic [3:0]  m_cs;
    logic [1:0]  m_size;
    logic        m_nrd;
    logic        e_rdy, e_samp, e_bad, e_valid, e_na;
    logic [1:0]  e_rsp;
    int unsigned bank;

    initial begin
        vecs[0]  = mk(1, TRN_NONSEQ, 32'h0100_0004, SZ_WORD,  0, 1, 0, 4'b0010, 1, 4'b0010);
        vecs[1]  = mk(1, TRN_NONSEQ, 32'h0000_0002, SZ_WORD,  1, 0, 1, 4'b0000, 0, 4'b0000);
        vecs[2]  = mk(1, TRN_NONSEQ, 32'h0500_0000, SZ_WORD,  0, 0, 1, 4'b0000, 1, 4'b0010);
        vecs[3]  = mk(1, TRN_NONSEQ, 32'h0300_0001, SZ_BYTE,  0, 1, 0, 4'b1000, 1, 4'b1000);
        vecs[4]  = mk(1, TRN_SEQ,    32'h0200_0002, SZ_HALF,  1, 1, 0, 4'b0100, 1, 4'b0100);
        vecs[5]  = mk(1, TRN_NONSEQ, 32'h0200_0001, SZ_HALF,  0, 0, 1, 4'b0000, 0, 4'b0000);
        vecs[6]  = mk(1, TRN_NONSEQ, 32'h0000_0000, SZ_DWORD, 0, 0, 1, 4'b0000, 0, 4'b0000);
        vecs[7]  = mk(1, TRN_IDLE,   32'h0100_0000, SZ_WORD,  0, 0, 0, 4'b0000, 0, 4'b0000);
        vecs[8]  = mk(1, TRN_BUSY,   32'h0100_0000, SZ_WORD,  0, 0, 0, 4'b0000, 0, 4'b0000);
        vecs[9]  = mk(0, TRN_NONSEQ, 32'h0100_0000, SZ_WORD,  0, 0, 0, 4'b0000, 0, 4'b0000);
        vecs[10] = mk(1, TRN_SEQ,    32'h0000_0008, SZ_WORD,  0, 1, 0, 4'b0001, 1, 4'b0001);
        vecs[11] = mk(1, TRN_NONSEQ, 32'h0400_0000, SZ_BYTE,  0, 0, 1, 4'b0000, 1, 4'b0001);
        vecs[12] = mk(1, TRN_NONSEQ, 32'h03FF_FFFC, SZ_WORD,  1, 1, 0, 4'b1000, 1, 4'b1000);

        // ---------------- reset values
        n_sys_reset = 1'b0;
        bus_idle();
        hwdata = '0; read_data = '0;
        smc_idle = 1'b1; smc_done = 1'b0; mac_done = 1'b0;
        cyc(); cyc();
        chk("rst hready", smc_hready, 1'b1);
        chk("rst hresp", smc_hresp, RSP_OKAY);
        chk("rst new_access", new_access, 1'b0);
        chk("rst addr", addr, 32'h0);
        chk("rst cs", cs, 4'b0000);
        chk("rst xfer_size", xfer_size, 2'b00);
        chk("rst n_read", n_read, 1'b0);
        chk("rst write_data", write_data, 32'h0);
        n_sys_reset = 1'b1;
        cyc();

        // ---------------- decode table
        for (int i = 0; i < 13; i++) begin
            v = vecs[i];
            aphase(v.trn, v.a, v.sz, v.wr);
            hsel = v.sel;
            #1;
            chk($sformatf("tbl%0d valid", i), smc_valid, v.ev);
            chk($sformatf("tbl%0d new_access", i), new_access, v.ev);
            chk($sformatf("tbl%0d hready", i), smc_hready, 1'b1);
            chk($sformatf("tbl%0d hresp", i), smc_hresp, RSP_OKAY);
            chk($sformatf("tbl%0d wrap valid", i), w_valid, v.evw);
            cyc();
            bus_idle();
            #1;
            if (v.ee) begin
                chk($sformatf("tbl%0d err1 hready", i), smc_hready, 1'b0);
                chk($sformatf("tbl%0d err1 hresp", i), smc_hresp, RSP_ERROR);
                chk($sformatf("tbl%0d err1 new_access", i), new_access, 1'b0);
                if (v.evw) chk($sformatf("tbl%0d wrap hresp", i), w_hresp, RSP_OKAY);
                cyc();
                chk($sformatf("tbl%0d err2 hready", i), smc_hready, 1'b1);
                chk($sformatf("tbl%0d err2 hresp", i), smc_hresp, RSP_ERROR);
            end else if (v.ev) begin
                chk($sformatf("tbl%0d cs", i), cs, v.ec);
                chk($sformatf("tbl%0d addr", i), addr, v.a);
                chk($sformatf("tbl%0d xfer_size", i), xfer_size, v.sz[1:0]);
                chk($sformatf("tbl%0d n_read", i), n_read, v.wr);
                chk($sformatf("tbl%0d busy hready", i), smc_hready, 1'b0);
                chk($sformatf("tbl%0d busy new_access", i), new_access, 1'b0);
            end else begin
                chk($sformatf("tbl%0d idle hready", i), smc_hready, 1'b1);
                chk($sformatf("tbl%0d idle new_access", i), new_access, 1'b0);
            end
            if (v.evw) chk($sformatf("tbl%0d wrap cs", i), w_cs, v.ecw);
            smc_done = 1'b1; mac_done = 1'b1;
            #1;
            chk($sformatf("tbl%0d done hready", i), smc_hready, 1'b1);
            cyc();
            smc_done = 1'b0; mac_done = 1'b0;
            #1;
            chk($sformatf("tbl%0d back idle", i), smc_hready, 1'b1);
            chk($sformatf("tbl%0d wrap back idle", i), w_hready, 1'b1);
        end

        // ---------------- read held until smc_done & mac_done
        aphase(TRN_NONSEQ, 32'h0100_0004, SZ_WORD, 1'b0);
        #1;
        chk("rd valid", smc_valid, 1'b1);
        chk("rd new_access", new_access, 1'b1);
        cyc();
        bus_idle();
        #1;
        chk("rd cs", cs, 4'b0010);
        chk("rd pulse ends", new_access, 1'b0);
        chk("rd hready wait", smc_hready, 1'b0);
        smc_done = 1'b1;
        #1;
        chk("rd hready no mac", smc_hready, 1'b0);
        cyc();
        chk("rd still no pulse", new_access, 1'b0);
        mac_done = 1'b1;
        #1;
        chk("rd hready done", smc_hready, 1'b1);
        cyc();
        smc_done = 1'b0; mac_done = 1'b0;
        #1;
        chk("rd idle", smc_hready, 1'b1);

        // ---------------- write stalled in PEND while core busy
        smc_idle = 1'b0;
        aphase(TRN_NONSEQ, 32'h0100_0000, SZ_WORD, 1'b1);
        #1;
        chk("pend valid", smc_valid, 1'b1);
        chk("pend no launch", new_access, 1'b0);
        cyc();
        bus_idle();
        hwdata = 32'hA5A5_5A5A;
        #1;
        chk("pend hready c1", smc_hready, 1'b0);
        chk("pend new_access c1", new_access, 1'b0);
        cyc();
        hwdata = 32'h1234_5678;
        #1;
        chk("pend write_data", write_data, 32'hA5A5_5A5A);
        chk("pend new_access c2", new_access, 1'b0);
        cyc();
        chk("pend new_access c3", new_access, 1'b0);
        smc_idle = 1'b1;
        #1;
        chk("pend launch", new_access, 1'b1);
        chk("pend launch hready", smc_hready, 1'b0);
        cyc();
        smc_idle = 1'b0;
        #1;
        chk("pend pulse ends", new_access, 1'b0);
        chk("pend write_data held", write_data, 32'hA5A5_5A5A);
        chk("pend n_read", n_read, 1'b1);
        smc_done = 1'b1; mac_done = 1'b1;
        #1;
        chk("pend done hready", smc_hready, 1'b1);
        cyc();
        smc_done = 1'b0; mac_done = 1'b0; smc_idle = 1'b1;

        // ---------------- back-to-back NONSEQ then SEQ
        aphase(TRN_NONSEQ, 32'h0000_0010, SZ_WORD, 1'b0);
        #1;
        chk("b2b first launch", new_access, 1'b1);
        cyc();
        aphase(TRN_SEQ, 32'h0000_0014, SZ_WORD, 1'b0);
        smc_done = 1'b1; mac_done = 1'b1;
        #1;
        chk("b2b hready", smc_hready, 1'b1);
        chk("b2b second valid", smc_valid, 1'b1);
        chk("b2b second launch", new_access, 1'b1);
        chk("b2b first addr", addr, 32'h0000_0010);
        cyc();
        bus_idle();
        smc_done = 1'b0; mac_done = 1'b0;
        #1;
        chk("b2b second addr", addr, 32'h0000_0014);
        chk("b2b pulse ends", new_access, 1'b0);
        chk("b2b busy", smc_hready, 1'b0);
        smc_done = 1'b1; mac_done = 1'b1;
        cyc();
        smc_done = 1'b0; mac_done = 1'b0;

        // ---------------- asynchronous reset during BUSY
        aphase(TRN_NONSEQ, 32'h0200_0000, SZ_WORD, 1'b0);
        cyc();
        bus_idle();
        #1;
        chk("arst busy cs", cs, 4'b0100);
        chk("arst busy hready", smc_hready, 1'b0);
        n_sys_reset = 1'b0;
        #1;
        chk("arst hready", smc_hready, 1'b1);
        chk("arst hresp", smc_hresp, RSP_OKAY);
        chk("arst cs", cs, 4'b0000);
        chk("arst addr", addr, 32'h0);
        chk("arst new_access", new_access, 1'b0);
        cyc();
        n_sys_reset = 1'b1;
        cyc();

        // ---------------- randomized traffic against the reference model
        m_pend = 1'b0; m_inflt = 1'b0; m_cap = 1'b0; m_err = 0;
        m_addr = '0; m_wd = '0; m_cs = '0; m_size = '0; m_nrd = 1'b0;
        for (int n = 0; n < 400; n++) begin
            hsel   = ($urandom % 5) != 0;
            htrans = 2'($urandom % 4);
            bank   = $urandom % 6;
            haddr  = (bank << 24) | (($urandom % 4 == 0) ? ($urandom % 8) : (($urandom % 64) << 2));
            hsize  = ($urandom % 5 == 0) ? SZ_DWORD : 3'($urandom % 3);
            hwrite = $urandom % 2;
            hwdata = $urandom;
            read_data = $urandom;
            smc_idle = ($urandom % 4) != 0;
            smc_done = $urandom % 2;
            mac_done = ($urandom % 4) != 0;
            #1;
            // Expected bus response from what is outstanding.
            if (m_err == 1)      e_rdy = 1'b0;
            else if (m_err == 2) e_rdy = 1'b1;
            else if (m_pend)     e_rdy = 1'b0;
            else if (m_inflt)    e_rdy = smc_done & mac_done;
            else                 e_rdy = 1'b1;
            e_rsp   = (m_err != 0) ? RSP_ERROR : RSP_OKAY;
            e_bad   = (hsize > 3'd2) || ((haddr % (32'd1 << hsize)) != 0) || ((haddr >> 24) >= 4);
            e_samp  = hsel && e_rdy && (htrans == TRN_NONSEQ || htrans == TRN_SEQ);
            e_valid = e_samp && !e_bad;
            e_na    = smc_idle && (m_pend || e_valid);
            chk("rnd hready", smc_hready, e_rdy);
            chk("rnd hresp", smc_hresp, e_rsp);
            chk("rnd valid", smc_valid, e_valid);
            chk("rnd new_access", new_access, e_na);
            chk("rnd addr", addr, m_addr);
            chk("rnd cs", cs, m_cs);
            chk("rnd xfer_size", xfer_size, m_size);
            chk("rnd n_read", n_read, m_nrd);
            chk("rnd write_data", write_data, m_wd);
            chk("rnd hrdata", smc_hrdata, read_data);
            if (new_access) chk("rnd launch while core busy", smc_idle, 1'b1);
            // Advance the model to the next cycle.
            if (m_cap) m_wd = hwdata;
            m_cap = e_valid && hwrite;
            if (m_pend && smc_idle) begin
                m_pend = 1'b0; m_inflt = 1'b1;
            end else if (m_inflt && smc_done && mac_done) begin
                m_inflt = 1'b0;
            end
            m_err = (m_err == 1) ? 2 : 0;
            if (e_samp) begin
                if (e_bad) begin
                    m_err = 1;
                end else begin
                    m_addr = haddr;
                    m_cs   = 4'(1 << (haddr >> 24));
                    m_size = hsize[1:0];
                    m_nrd  = hwrite;
                    if (smc_idle) m_inflt = 1'b1;
                    else          m_pend  = 1'b1;
                end
            end
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
